pr_arbiter: RTL

PR_ARBITER -- requirements
Module: pr_arbiter

---
 rtl/pr_arbiter_if.sv | 31 +++
 rtl/pr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pr_arbiter_if.sv
// Bundle of request/grant signals between the eight requesters and
// pr_arbiter. The arbiter takes the slave view; the requester side
// (or a bench) takes the master view.
//
// Handshake: a requester keeps req[i] high for as long as it wants the
// resource. Being granted is shown by gnt[i] (registered, one-hot) and
// gnt_valid. The granted requester returns the resource either with a
// one-cycle done strobe or by dropping req[i]. A grant that reaches the
// hold limit is withdrawn, and timeout pulses for one cycle. Between any
// two grants there is always at least one cycle with gnt == 0.
interface pr_arbiter_if;
   logic [7:0] req;        // request vector, bit i = requester i
   logic       mode;       // 0 fixed priority, 1 round-robin
   logic       done;       // release strobe from the granted requester
   logic [7:0] gnt;        // one-hot grant, registered
   logic [2:0] gnt_id;     // index of the granted requester, 0 if none
   logic       gnt_valid;  // OR of gnt
   logic       timeout;    // one-cycle pulse after a forced release
   logic       dbg_state;  // FSM state: 0 IDLE, 1 GRANT
   logic [2:0] dbg_ptr;    // round-robin pointer (last granted id)

   modport slave (
      input  req, mode, done,
      output gnt, gnt_id, gnt_valid, timeout, dbg_state, dbg_ptr
   );

   modport master (
      output req, mode, done,
      input  gnt, gnt_id, gnt_valid, timeout, dbg_state, dbg_ptr
   );
endinterface

// File: rtl/pr_arbiter.sv
// Eight-way arbiter with fixed-priority or round-robin selection and an
// optional hold-time limit. Two-state FSM: IDLE (nothing granted) and
// GRANT (exactly one requester owns the resource). A new winner is only
// picked in IDLE, so a grant is never preempted and two grants are
// always separated by at least one idle cycle.
module pr_arbiter #(
   parameter int unsigned MAX_HOLD = 16   // 0 disables the hold limit
) (
   input  logic         clk,
   input  logic         rst_n,
   pr_arbiter_if.slave  bus
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   // Hold counter value at which the grant is forcibly released.
   localparam int unsigned LP_HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [7:0]  LP_HOLD_LAST   = 8'(LP_HOLD_LAST_I);
   localparam logic        LP_LIMIT_EN    = (MAX_HOLD != 0);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_gnt;
   logic [7:0] w_gnt_nxt;
   logic [2:0] r_gnt_id;
   logic [2:0] w_gnt_id_nxt;
   logic       r_timeout;
   logic       w_timeout_nxt;
   logic [2:0] r_ptr;
   logic [2:0] w_ptr_nxt;
   logic [7:0] r_hold;
   logic [7:0] w_hold_nxt;

   logic [2:0] w_fixed_id;
   logic [2:0] w_rr_id;
   logic       w_rr_found;
   logic [2:0] w_rr_idx;
   logic [2:0] w_win_id;
   logic       w_any_req;

   logic       w_rel_done;
   logic       w_rel_drop;
   logic       w_rel_limit;
   logic       w_release;

   assign w_any_req = |bus.req;

   // Fixed priority: highest set request bit wins (later iterations override).
   always_comb begin
      w_fixed_id = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (bus.req[i]) begin
            w_fixed_id = 3'(i);
         end
      end
   end

   // Round-robin: search ptr-1, ptr-2, ... wrapping, ending at ptr itself,
   // so the last granted requester is considered last.
   always_comb begin
      w_rr_id    = 3'd0;
      w_rr_found = 1'b0;
      w_rr_idx   = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         w_rr_idx = r_ptr - 3'(k);
         if (!w_rr_found && bus.req[w_rr_idx]) begin
            w_rr_id    = w_rr_idx;
            w_rr_found = 1'b1;
         end
      end
   end

   assign w_win_id = bus.mode ? w_rr_id : w_fixed_id;

   // Release conditions, only meaningful while in GRANT.
   assign w_rel_done  = bus.done;
   assign w_rel_drop  = !bus.req[r_gnt_id];
   assign w_rel_limit = LP_LIMIT_EN && (r_hold == LP_HOLD_LAST);
   assign w_release   = w_rel_done || w_rel_drop || w_rel_limit;

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_id_nxt  = r_gnt_id;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            // done is meaningless here; mode is sampled through w_win_id.
            if (w_any_req) begin
               w_state_nxt  = S_GRANT;
               w_gnt_nxt    = 8'd1 << w_win_id;
               w_gnt_id_nxt = w_win_id;
               w_hold_nxt   = 8'd0;
            end else begin
               w_gnt_nxt    = 8'd0;
               w_gnt_id_nxt = 3'd0;
            end
         end

         S_GRANT: begin
            if (w_release) begin
               w_state_nxt   = S_IDLE;
               w_gnt_nxt     = 8'd0;
               w_gnt_id_nxt  = 3'd0;
               w_ptr_nxt     = r_gnt_id;
               w_hold_nxt    = 8'd0;
               // Only a release caused purely by the hold limit is a timeout.
               w_timeout_nxt = w_rel_limit && !w_rel_done && !w_rel_drop;
            end else begin
               w_hold_nxt = r_hold + 8'd1;
            end
         end

         default: begin
            w_state_nxt  = S_IDLE;
            w_gnt_nxt    = 8'd0;
            w_gnt_id_nxt = 3'd0;
            w_hold_nxt   = 8'd0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= 8'd0;
         r_gnt_id  <= 3'd0;
         r_timeout <= 1'b0;
         r_ptr     <= 3'd0;
         r_hold    <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_timeout <= w_timeout_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hold    <= w_hold_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_id    = r_gnt_id;
   assign bus.gnt_valid = |r_gnt;
   assign bus.timeout   = r_timeout;
   assign bus.dbg_state = r_state;
   assign bus.dbg_ptr   = r_ptr;

endmodule
